tg_write_arbiter: RTL and testbench
===================================

TG_WRITE_ARBITER -- requirements
Module: tg_write_arbiter

Interface
REQ-001 Parameter SCREEN_WIDTH, default 76, grid columns.
REQ-002 Parameter SCREEN_HEIGHT, default 44, grid rows.
REQ-003 Parameter CLEAR_CHAR, default 8'h20, fill code written by the clear sweep.
REQ-004 Derived constants:
- CELLS = SCREEN_WIDTH*SCREEN_HEIGHT (3344 at defaults).
- ADDR_W = $clog2(CELLS) (12 at defaults).
REQ-005 clk_in  in  1  the block's only clock.
REQ-006 rst_in  in  1  reset; asynchronous, active-low.
REQ-007 key_valid  in  1  keystroke write request.
REQ-008 key_addr  in  ADDR_W  keystroke cell address.
REQ-009 key_data  in  8  keystroke character code.
REQ-010 key_ready  out  1  keystroke request accepted this cycle.
REQ-011 prt_valid  in  1  print-engine write request.
REQ-012 prt_addr  in  ADDR_W  print cell address.
REQ-013 prt_data  in  8  print character code.
REQ-014 prt_ready  out  1  print request accepted this cycle.
REQ-015 clr_req  in  1  single-cycle pulse that starts a full-grid clear.
REQ-016 clr_busy  out  1  clear sweep in progress.
REQ-017 drop_out  out  1  one-cycle pulse: the accepted request was out of range and discarded.
REQ-018 tg_we  out  1  grid write enable to character_sprites.
REQ-019 tg_addr  out  ADDR_W  grid write address.
REQ-020 tg_input  out  8  grid write data.

Function
REQ-021 FSM states:
- IDLE: arbitrates the requester ports.
- CLEAR: runs the sweep.
REQ-022 A transfer occurs on a port when valid and ready are both high on the same clk_in edge.
REQ-023 In IDLE with clr_req low, exactly one valid port gets ready.
- Only one port valid: that port is granted.
- Both valid: the port not granted by the previous transfer is granted (round-robin).
REQ-024 key_ready and prt_ready are combinational from state, clr_req, both valids and the last-grant pointer; they are low in CLEAR and whenever clr_req is high.
REQ-025 A requester holds valid, addr and data stable until ready; ready never depends on addr or data.
REQ-026 An in-range transfer (addr < CELLS) registers tg_we=1 with the granted addr/data on the next cycle (latency 1); tg_we=0 on every other IDLE cycle.
REQ-027 An out-of-range transfer (addr >= CELLS) is accepted, then:
- tg_we stays 0 on the next cycle;
- drop_out pulses for that cycle;
- the last-grant pointer still updates.
REQ-028 clr_req in IDLE takes priority over both ports in the same cycle and moves the FSM to CLEAR.
REQ-029 CLEAR sweep behaviour:
- Writes CLEAR_CHAR to addresses 0..CELLS-1, one per cycle, with tg_we continuously high.
- The first write appears the cycle after clr_req.
- The sweep lasts exactly CELLS cycles.
REQ-030 clr_busy is high on every cycle in which tg_we carries a sweep write, including the cycle of address CELLS-1, and low otherwise.
REQ-031 After address CELLS-1 the FSM returns to IDLE, and ready may assert in that same cycle.
REQ-032 clr_req during CLEAR is ignored: no restart, no queuing.
REQ-033 The sweep address counter is ADDR_W bits wide, compares against CELLS-1, and never wraps past CELLS-1.

Reset
REQ-034 While rst_in is low, the following are forced asynchronously:
- state = IDLE; sweep counter = 0; last-grant pointer favours key on the first tie.
- tg_we = 0, tg_addr = 0, tg_input = 0, clr_busy = 0, drop_out = 0.
- key_ready = 0, prt_ready = 0.
REQ-035 Reset asserted mid-sweep abandons the sweep; after release the block is in IDLE and no pending clear remains.

Structure
REQ-036 Shared package tg_pkg holds:
- SCREEN_WIDTH, SCREEN_HEIGHT, CELLS, ADDR_W, CLEAR_CHAR;
- the FSM state enum;
- the requester id enum (KEY, PRT).
REQ-037 The round-robin grant logic is one sub-module, rr_arbiter2 (two requests, pointer update on transfer); all other logic sits in tg_write_arbiter.

Verification
REQ-038 Single request: key_valid=1, key_addr=5, key_data=8'h41 for one cycle.
- key_ready=1 that cycle.
- Next cycle: tg_we=1, tg_addr=5, tg_input=8'h41.
REQ-039 Contention: both ports valid for 4 cycles after reset, with distinct addresses and data.
- Grants are key, prt, key, prt.
- tg_addr and tg_input follow the same order, each one cycle after its grant.
REQ-040 Out of range: prt_addr=3344, prt_valid=1.
- prt_ready=1.
- Next cycle: tg_we=0, drop_out=1.
REQ-041 Clear: clr_req pulse while key_valid=1.
- key_ready=0 throughout.
- 3344 consecutive writes of 8'h20 to addresses 0..3343, with clr_busy high for those 3344 cycles.
- key is then granted.
- A second clr_req at sweep address 100 changes nothing.
REQ-042 Reset mid-sweep: drop rst_in at sweep address 1000.
- All outputs go to 0 immediately.
- After release, tg_we stays 0 until a new request arrives.

Source files
------------

// File: rtl/tg_pkg.sv
// Shared definitions for the text-grid write arbiter.
//   - Default grid geometry and the derived cell count / address width.
//   - CLEAR_CHAR: the fill code written by the clear sweep.
//   - state_e:    arbiter FSM states.
//   - req_id_e:   requester identities, also used as the last-grant pointer.
package tg_pkg;

   localparam int          SCREEN_WIDTH  = 76;
   localparam int          SCREEN_HEIGHT = 44;
   localparam int          CELLS         = SCREEN_WIDTH * SCREEN_HEIGHT;
   localparam int          ADDR_W        = $clog2(CELLS);
   localparam logic [7:0]  CLEAR_CHAR    = 8'h20;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   typedef enum logic {
      REQ_KEY = 1'b0,
      REQ_PRT = 1'b1
   } req_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk_in, rst_in : clock, asynchronous active-low reset
//   en             : arbitration allowed this cycle (otherwise no grant)
//   req[1:0]       : request vector, bit 0 = key, bit 1 = print
//   gnt[1:0]       : one-hot grant (or zero), combinational
// The pointer remembers who won the last transfer; on a tie the other
// requester wins. Every grant is a transfer because a grant is only ever
// given to an asserted request.
module rr_arbiter2
   import tg_pkg::*;
(
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   req_id_e last_q, last_d;

   always_comb begin
      gnt    = 2'b00;
      last_d = last_q;
      if (en) begin
         if (req[0] && req[1]) begin
            gnt = (last_q == REQ_KEY) ? 2'b10 : 2'b01;
         end else begin
            gnt = req;
         end
      end
      if (gnt[0]) last_d = REQ_KEY;
      if (gnt[1]) last_d = REQ_PRT;
   end

   // Reset as if print won last, so key wins the first tie.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         last_q <= REQ_PRT;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/tg_write_arbiter.sv
// Text-grid write arbiter: merges keystroke and print-engine writes into a
// single grid write port, and can sweep the whole grid with CLEAR_CHAR.
//   clk_in, rst_in          : clock, asynchronous active-low reset
//   key_valid/addr/data     : keystroke request, key_ready = accepted
//   prt_valid/addr/data     : print request,     prt_ready = accepted
//   clr_req                 : one-cycle pulse starting a full-grid clear
//   clr_busy                : high while tg_we carries a sweep write
//   drop_out                : pulse, an accepted request was out of range
//   tg_we/tg_addr/tg_input  : registered grid write port
module tg_write_arbiter
#(
   parameter  int         SCREEN_WIDTH  = tg_pkg::SCREEN_WIDTH,
   parameter  int         SCREEN_HEIGHT = tg_pkg::SCREEN_HEIGHT,
   parameter  logic [7:0] CLEAR_CHAR    = tg_pkg::CLEAR_CHAR,
   localparam int         CELLS         = SCREEN_WIDTH * SCREEN_HEIGHT,
   localparam int         ADDR_W        = $clog2(CELLS)
)
(
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              key_valid,
   input  logic [ADDR_W-1:0] key_addr,
   input  logic [7:0]        key_data,
   output logic              key_ready,
   input  logic              prt_valid,
   input  logic [ADDR_W-1:0] prt_addr,
   input  logic [7:0]        prt_data,
   output logic              prt_ready,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              drop_out,
   output logic              tg_we,
   output logic [ADDR_W-1:0] tg_addr,
   output logic [7:0]        tg_input
);

   import tg_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d, cnt_nxt;
   logic              tg_we_q, tg_we_d;
   logic [ADDR_W-1:0] tg_addr_q, tg_addr_d;
   logic [7:0]        tg_input_q, tg_input_d;
   logic              clr_busy_q, clr_busy_d;
   logic              drop_q, drop_d;

   logic              arb_en;
   logic [1:0]        gnt;
   logic              key_in_rng, prt_in_rng;

   // Ready is held low during reset even though the state already reads IDLE.
   assign arb_en = rst_in && (state_q == ST_IDLE) && !clr_req;

   rr_arbiter2 u_arb (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .en     (arb_en),
      .req    ({prt_valid, key_valid}),
      .gnt    (gnt)
   );

   assign key_ready = gnt[0];
   assign prt_ready = gnt[1];

   // Compare in 32 bits so a power-of-two CELLS still works.
   assign key_in_rng = (32'(key_addr) < 32'(CELLS));
   assign prt_in_rng = (32'(prt_addr) < 32'(CELLS));

   assign cnt_nxt = cnt_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tg_we_d    = 1'b0;
      tg_addr_d  = tg_addr_q;
      tg_input_d = tg_input_q;
      clr_busy_d = 1'b0;
      drop_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (clr_req) begin
               // Address 0 goes out on the next cycle; a one-cell grid is
               // finished by that single write.
               state_d    = (CELLS == 1) ? ST_IDLE : ST_CLEAR;
               cnt_d      = '0;
               tg_we_d    = 1'b1;
               tg_addr_d  = '0;
               tg_input_d = CLEAR_CHAR;
               clr_busy_d = 1'b1;
            end else if (gnt[0]) begin
               if (key_in_rng) begin
                  tg_we_d    = 1'b1;
                  tg_addr_d  = key_addr;
                  tg_input_d = key_data;
               end else begin
                  drop_d     = 1'b1;
               end
            end else if (gnt[1]) begin
               if (prt_in_rng) begin
                  tg_we_d    = 1'b1;
                  tg_addr_d  = prt_addr;
                  tg_input_d = prt_data;
               end else begin
                  drop_d     = 1'b1;
               end
            end
         end
         ST_CLEAR: begin
            // cnt_q is the address currently on tg_addr. Leaving CLEAR on the
            // edge that issues the last address lets ready assert while that
            // final sweep write is still on the port.
            cnt_d      = cnt_nxt;
            tg_we_d    = 1'b1;
            tg_addr_d  = cnt_nxt;
            tg_input_d = CLEAR_CHAR;
            clr_busy_d = 1'b1;
            if (cnt_nxt == LAST_ADDR) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         tg_we_q    <= 1'b0;
         tg_addr_q  <= '0;
         tg_input_q <= '0;
         clr_busy_q <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tg_we_q    <= tg_we_d;
         tg_addr_q  <= tg_addr_d;
         tg_input_q <= tg_input_d;
         clr_busy_q <= clr_busy_d;
         drop_q     <= drop_d;
      end
   end

   assign tg_we    = tg_we_q;
   assign tg_addr  = tg_addr_q;
   assign tg_input = tg_input_q;
   assign clr_busy = clr_busy_q;
   assign drop_out = drop_q;

endmodule

// File: tb/tb_tg_write_arbiter.sv
// Directed bench for tg_write_arbiter at default geometry (3344 cells).
module tb_tg_write_arbiter;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        key_valid, prt_valid, clr_req;
   logic [11:0] key_addr, prt_addr;
   logic [7:0]  key_data, prt_data;
   logic        key_ready, prt_ready, clr_busy, drop_out, tg_we;
   logic [11:0] tg_addr;
   logic [7:0]  tg_input;

   int checks = 0;
   int errors = 0;

   always #5 clk_in = ~clk_in;

   tg_write_arbiter dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .key_valid (key_valid),
      .key_addr  (key_addr),
      .key_data  (key_data),
      .key_ready (key_ready),
      .prt_valid (prt_valid),
      .prt_addr  (prt_addr),
      .prt_data  (prt_data),
      .prt_ready (prt_ready),
      .clr_req   (clr_req),
      .clr_busy  (clr_busy),
      .drop_out  (drop_out),
      .tg_we     (tg_we),
      .tg_addr   (tg_addr),
      .tg_input  (tg_input)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      assert (act === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_we"},    tg_we,     0);
      chk({tag, "_addr"},  tg_addr,   0);
      chk({tag, "_data"},  tg_input,  0);
      chk({tag, "_busy"},  clr_busy,  0);
      chk({tag, "_drop"},  drop_out,  0);
      chk({tag, "_krdy"},  key_ready, 0);
      chk({tag, "_prdy"},  prt_ready, 0);
   endtask

   // Contention vectors: key offers 10/A0 then 11/A1 (12/A2 is never taken),
   // print offers 20/B0 then 21/B1 (22/B2 never taken).
   logic [11:0] ka [3] = '{12'd10, 12'd11, 12'd12};
   logic [7:0]  kd [3] = '{8'hA0, 8'hA1, 8'hA2};
   logic [11:0] pa [3] = '{12'd20, 12'd21, 12'd22};
   logic [7:0]  pd [3] = '{8'hB0, 8'hB1, 8'hB2};
   // Expected writes in grant order key, prt, key, prt.
   logic [11:0] ea [4] = '{12'd10, 12'd20, 12'd11, 12'd21};
   logic [7:0]  ed [4] = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};

   initial begin
      int ki, pi, bad, found;
      rst_in = 1'b1; key_valid = 0; prt_valid = 0; clr_req = 0;
      key_addr = '0; key_data = '0; prt_addr = '0; prt_data = '0;

      // Reset state, valids high to show ready is forced low.
      #2 rst_in = 1'b0;
      key_valid = 1; prt_valid = 1;
      #1 chk_all_zero("reset");
      repeat (2) @(negedge clk_in);
      key_valid = 0; prt_valid = 0;
      rst_in = 1'b1;
      @(negedge clk_in);
      chk("idle_we", tg_we, 0);

      // Contention straight after reset: key, prt, key, prt.
      ki = 0; pi = 0;
      key_valid = 1; key_addr = ka[0]; key_data = kd[0];
      prt_valid = 1; prt_addr = pa[0]; prt_data = pd[0];
      for (int g = 0; g < 4; g++) begin
         #1;
         chk($sformatf("rr%0d_krdy", g), key_ready, (g % 2 == 0) ? 1 : 0);
         chk($sformatf("rr%0d_prdy", g), prt_ready, (g % 2 == 0) ? 0 : 1);
         @(posedge clk_in);
         #1;
         if (g % 2 == 0) begin ki++; key_addr = ka[ki]; key_data = kd[ki]; end
         else            begin pi++; prt_addr = pa[pi]; prt_data = pd[pi]; end
         @(negedge clk_in);
         chk($sformatf("rr%0d_we", g),   tg_we,    1);
         chk($sformatf("rr%0d_addr", g), tg_addr,  ea[g]);
         chk($sformatf("rr%0d_data", g), tg_input, ed[g]);
      end
      key_valid = 0; prt_valid = 0;

      // Single keystroke.
      @(negedge clk_in);
      key_valid = 1; key_addr = 12'd5; key_data = 8'h41;
      #1 chk("single_krdy", key_ready, 1);
      @(posedge clk_in); #1 key_valid = 0;
      @(negedge clk_in);
      chk("single_we",   tg_we,    1);
      chk("single_addr", tg_addr,  5);
      chk("single_data", tg_input, 8'h41);
      chk("single_drop", drop_out, 0);
      @(negedge clk_in);
      chk("single_we_off", tg_we, 0);

      // Out-of-range print write is accepted then dropped.
      prt_valid = 1; prt_addr = 12'd3344; prt_data = 8'h77;
      #1 chk("oor_prdy", prt_ready, 1);
      @(posedge clk_in); #1 prt_valid = 0;
      @(negedge clk_in);
      chk("oor_we",   tg_we,    0);
      chk("oor_drop", drop_out, 1);
      @(negedge clk_in);
      chk("oor_drop_off", drop_out, 0);

      // Clear with a keystroke pending; second clr_req at address 100.
      key_valid = 1; key_addr = 12'd7; key_data = 8'h55; clr_req = 1;
      #1 chk("clr_krdy", key_ready, 0);
      @(posedge clk_in); #1 clr_req = 0;
      bad = 0;
      for (int i = 0; i < 3344; i++) begin
         @(negedge clk_in);
         if (tg_we !== 1'b1 || tg_addr !== 12'(i) || tg_input !== 8'h20 || clr_busy !== 1'b1)
            bad++;
         if (i < 3343 && key_ready !== 1'b0) bad++;
         if (i == 3343) chk("sweep_end_krdy", key_ready, 1);
         clr_req = (i == 100);
      end
      chk("sweep_bad_cycles", bad, 0);
      @(posedge clk_in); #1 key_valid = 0;
      @(negedge clk_in);
      chk("post_sweep_we",   tg_we,    1);
      chk("post_sweep_addr", tg_addr,  7);
      chk("post_sweep_data", tg_input, 8'h55);
      chk("post_sweep_busy", clr_busy, 0);
      @(negedge clk_in);
      chk("no_restart_we",   tg_we,    0);
      chk("no_restart_busy", clr_busy, 0);

      // Reset in the middle of a sweep.
      clr_req = 1;
      @(posedge clk_in); #1 clr_req = 0;
      found = 0;
      for (int n = 0; n < 2000 && found == 0; n++) begin
         @(negedge clk_in);
         if (tg_we === 1'b1 && tg_addr === 12'd1000) found = 1;
      end
      chk("reach_addr_1000", found, 1);
      rst_in = 1'b0; key_valid = 1;
      #1 chk_all_zero("midreset");
      key_valid = 0;
      @(negedge clk_in);
      rst_in = 1'b1;
      bad = 0;
      repeat (5) begin
         @(negedge clk_in);
         if (tg_we !== 1'b0 || clr_busy !== 1'b0) bad++;
      end
      chk("after_reset_quiet", bad, 0);
      key_valid = 1; key_addr = 12'd9; key_data = 8'h66;
      #1 chk("after_reset_krdy", key_ready, 1);
      @(posedge clk_in); #1 key_valid = 0;
      @(negedge clk_in);
      chk("after_reset_we",   tg_we,   1);
      chk("after_reset_addr", tg_addr, 9);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
